// File: rtl/err_check_seq.sv
`default_nettype none
// ============================================================================
//  Module   : err_check_seq
//  Purpose  : Error-check sequencer for the linear-regression training path.
//             Issues each sample index, waits LAT cycles for the datapath,
//             pulses h_ld, accumulates a saturating sum of squared errors and
//             reports convergence against a runtime threshold.
//  Revision : 1.0 - initial release
// ============================================================================
module err_check_seq #(
    parameter int N_SAMPLES = 150,
    parameter int LAT       = 2,
    parameter int EW        = 16,
    parameter int AW        = 40,
    localparam int ADDR_W   = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic signed [EW-1:0] err_in,
    input  logic [AW-1:0]        threshold,
    output logic [ADDR_W-1:0]    sample_addr,
    output logic                 issue,
    output logic                 h_ld,
    output logic                 ready,
    output logic                 done,
    output logic [AW-1:0]        sse,
    output logic                 converged
);

    // State encoding
    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_ISSUE  = 3'd1;
    localparam logic [2:0] c_WAIT   = 3'd2;
    localparam logic [2:0] c_LOAD   = 3'd3;
    localparam logic [2:0] c_FINISH = 3'd4;

    // Wait counter only has to hold LAT-1
    localparam int CW = (LAT > 2) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0]     c_WAIT_INIT = CW'((LAT > 0) ? (LAT - 1) : 0);
    localparam logic [ADDR_W-1:0] c_LAST      = ADDR_W'(N_SAMPLES - 1);

    logic [2:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [AW-1:0]     r_sse;
    logic              r_conv;
    logic              r_armed;
    logic              r_issue;
    logic              r_h_ld;
    logic              r_done;
    logic              r_ready;

    logic [2:0]               w_state_nxt;
    logic                     w_launch;
    logic                     w_abort;
    logic                     w_last;
    logic signed [2*EW-1:0]   w_prod;
    logic [2*EW-1:0]          w_sq;
    logic [AW:0]              w_sum;
    logic [AW-1:0]            w_sse_nxt;
    logic                     w_conv_nxt;

    // A held start launches only one run: armed must see start low first
    assign w_launch = (r_state == c_IDLE) && start && r_armed;
    assign w_abort  = abort && (r_state != c_IDLE);
    assign w_last   = (r_addr == c_LAST);

    // Signed square fits in 2*EW bits even for the most negative input,
    // so reinterpreting it as unsigned is exact
    assign w_prod     = err_in * err_in;
    assign w_sq       = w_prod;
    assign w_sum      = {1'b0, r_sse} + (AW + 1)'(w_sq);
    assign w_sse_nxt  = w_sum[AW] ? {AW{1'b1}} : w_sum[AW-1:0];
    assign w_conv_nxt = (w_sse_nxt < threshold);

    // Next-state selection; abort overrides every non-idle transition
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_launch) w_state_nxt = c_ISSUE;
            c_ISSUE:  w_state_nxt = (LAT > 0) ? c_WAIT : c_LOAD;
            c_WAIT:   if (r_cnt == '0) w_state_nxt = c_LOAD;
            c_LOAD:   w_state_nxt = w_last ? c_FINISH : c_ISSUE;
            c_FINISH: w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt = c_IDLE;
        end
    end

    // State, datapath registers and registered Moore strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_sse   <= '0;
            r_conv  <= 1'b0;
            r_armed <= 1'b1;
            r_issue <= 1'b0;
            r_h_ld  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_issue <= (w_state_nxt == c_ISSUE);
            r_h_ld  <= (w_state_nxt == c_LOAD);
            r_done  <= (w_state_nxt == c_FINISH);
            r_ready <= (w_state_nxt == c_IDLE);

            if (!start) begin
                r_armed <= 1'b1;
            end else if (w_launch) begin
                r_armed <= 1'b0;
            end

            if (w_launch) begin
                r_addr <= '0;
                r_sse  <= '0;
                r_conv <= 1'b0;
            end

            if (w_abort) begin
                // Partial SSE is kept for inspection; the verdict is not
                r_conv <= 1'b0;
            end else begin
                case (r_state)
                    c_ISSUE: r_cnt <= c_WAIT_INIT;
                    c_WAIT: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    c_LOAD: begin
                        r_sse <= w_sse_nxt;
                        if (w_last) begin
                            r_conv <= w_conv_nxt;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sample_addr = r_addr;
    assign issue       = r_issue;
    assign h_ld        = r_h_ld;
    assign done        = r_done;
    assign ready       = r_ready;
    assign sse         = r_sse;
    assign converged   = r_conv;

endmodule
`default_nettype wire
